// File: rtl/bandit_pkg.sv
// Shared types and constants for the action/reward arbiter.
// The state enum is shared so the top-level FSM and any wrappers agree on the encoding.
package bandit_pkg;

    localparam int ACTION_WIDTH = 8;
    localparam int REWARD_WIDTH = 8;

    // Reward returned to the agent when a requester never answers (-128).
    localparam logic [REWARD_WIDTH-1:0] REWARD_PENALTY = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACTUATING = 2'd1,
        ST_OBSERVING = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner search.
// The search starts at the requester after the last winner and wraps around.
// The grant is one-hot, or zero when there are no requests.
module rr_arbiter
    import bandit_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_grant
);

    logic [IW-1:0] w_idx;
    logic          w_found;

    // First requester found walking upward from last+1; the last winner itself is checked last.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = IW'((int'(i_last) + k) % N);
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/action_arbiter.sv
// Shares one action-value agent among N requesters, one action/reward transaction at a time.
// Optional feature: define ACTION_ARBITER_TIMEOUT_EN to give up on a silent requester.
// After TIMEOUT observing cycles without a reward, the agent receives REWARD_PENALTY instead.
//
//  state        | meaning
//  -------------+--------------------------------------------------------------
//  ST_IDLE      | no owner; the round-robin winner is registered when any request is high
//  ST_ACTUATING | agent action routed to the granted requester
//  ST_OBSERVING | granted requester's reward routed back to the agent
module action_arbiter
    import bandit_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [N-1:0]                 i_request,
    input  logic [N-1:0]                 i_greedy,
    input  logic                         i_agent_action_valid,
    input  logic [ACTION_WIDTH-1:0]      i_agent_action_data,
    output logic                         o_agent_action_ready,
    output logic                         o_agent_action_gready,
    output logic                         o_agent_reward_valid,
    output logic [REWARD_WIDTH-1:0]      o_agent_reward_data,
    input  logic                         i_agent_reward_ready,
    output logic [N-1:0]                 o_action_valid,
    input  logic [N-1:0]                 i_action_ready,
    output logic [ACTION_WIDTH-1:0]      o_action_data,
    input  logic [N-1:0]                 i_reward_valid,
    output logic [N-1:0]                 o_reward_ready,
    input  logic [N*REWARD_WIDTH-1:0]    i_reward_data,
    output logic [N-1:0]                 o_grant
);

    localparam int IW = $clog2(N);

    if (N < 2 || N > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_params
        $error("action_arbiter: N must be 2..8 and TIMEOUT 1..255");
    end

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    logic [N-1:0]           r_grant;
    logic [IW-1:0]          r_last;
    logic [IW-1:0]          w_gidx;
    logic [N-1:0]           w_rr_grant;
    logic                   w_action_hs;
    logic                   w_reward_hs;
    logic                   w_timed_out;
    logic [REWARD_WIDTH-1:0] w_rdata [N];

    rr_arbiter #(
        .N  (N),
        .IW (IW)
    ) u_rr (
        .i_req   (i_request),
        .i_last  (r_last),
        .o_grant (w_rr_grant)
    );

    // Unpack the per-requester reward buses so they can be indexed by the owner.
    for (genvar gi = 0; gi < N; gi++) begin : g_rdata
        assign w_rdata[gi] = i_reward_data[gi*REWARD_WIDTH +: REWARD_WIDTH];
    end

    // Binary index of the current owner; zero while idle, where it is not used.
    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < N; i++) begin
            if (r_grant[i]) begin
                w_gidx = IW'(i);
            end
        end
    end

`ifdef ACTION_ARBITER_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

    logic [7:0] r_timer;

    // Down-counter loaded on entry to OBSERVING; it freezes while the requester offers a reward.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_timer <= '0;
        end else if (w_action_hs) begin
            r_timer <= TIMEOUT_L;
        end else if (w_reward_hs) begin
            r_timer <= '0;
        end else if (r_state == ST_OBSERVING && !w_timed_out && !i_reward_valid[w_gidx]) begin
            r_timer <= r_timer - 8'd1;
        end
    end

    assign w_timed_out = (r_state == ST_OBSERVING) && (r_timer == 8'd0);
`else
    assign w_timed_out = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and handshake routing between the owner and the agent.
    always_comb begin
        w_state_nxt           = r_state;
        w_action_hs           = 1'b0;
        w_reward_hs           = 1'b0;
        o_action_valid        = '0;
        o_action_data         = '0;
        o_agent_action_ready  = 1'b0;
        o_agent_action_gready = 1'b1;
        o_reward_ready        = '0;
        o_agent_reward_valid  = 1'b0;
        o_agent_reward_data   = '0;
        case (r_state)
            ST_IDLE: begin
                if (|i_request) begin
                    w_state_nxt = ST_ACTUATING;
                end
            end
            ST_ACTUATING: begin
                o_agent_action_gready  = i_greedy[w_gidx];
                o_action_valid[w_gidx] = i_agent_action_valid;
                o_action_data          = i_agent_action_data;
                o_agent_action_ready   = i_action_ready[w_gidx];
                if (i_agent_action_valid && i_action_ready[w_gidx]) begin
                    w_action_hs = 1'b1;
                    w_state_nxt = ST_OBSERVING;
                end
            end
            ST_OBSERVING: begin
                o_agent_action_gready = i_greedy[w_gidx];
                if (w_timed_out) begin
                    // The requester is ignored from here on; the agent is given the penalty.
                    o_agent_reward_valid = 1'b1;
                    o_agent_reward_data  = REWARD_PENALTY;
                    if (i_agent_reward_ready) begin
                        w_reward_hs = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    o_agent_reward_valid   = i_reward_valid[w_gidx];
                    o_agent_reward_data    = w_rdata[w_gidx];
                    o_reward_ready[w_gidx] = i_agent_reward_ready;
                    if (i_reward_valid[w_gidx] && i_agent_reward_ready) begin
                        w_reward_hs = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Owner register and round-robin pointer. Reset points at N-1 so requester 0 is served first.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_grant <= '0;
            r_last  <= IW'(N - 1);
        end else if (r_state == ST_IDLE && (|i_request)) begin
            r_grant <= w_rr_grant;
        end else if (w_reward_hs) begin
            r_grant <= '0;
            r_last  <= w_gidx;
        end
    end

    assign o_grant = r_grant;

endmodule

// File: tb/tb_action_arbiter.sv
// Directed bench for action_arbiter with N=4 and TIMEOUT=4.
// The timeout scenario runs only when ACTION_ARBITER_TIMEOUT_EN is defined.
module tb_action_arbiter;

    localparam int N = 4;

    logic             i_clk = 1'b0;
    logic             i_rst_n;
    logic [N-1:0]     i_request;
    logic [N-1:0]     i_greedy;
    logic             i_agent_action_valid;
    logic [7:0]       i_agent_action_data;
    logic             o_agent_action_ready;
    logic             o_agent_action_gready;
    logic             o_agent_reward_valid;
    logic [7:0]       o_agent_reward_data;
    logic             i_agent_reward_ready;
    logic [N-1:0]     o_action_valid;
    logic [N-1:0]     i_action_ready;
    logic [7:0]       o_action_data;
    logic [N-1:0]     i_reward_valid;
    logic [N-1:0]     o_reward_ready;
    logic [N*8-1:0]   i_reward_data;
    logic [N-1:0]     o_grant;

    int n_cmp = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    action_arbiter #(
        .N       (N),
        .TIMEOUT (4)
    ) dut (
        .i_clk                 (i_clk),
        .i_rst_n               (i_rst_n),
        .i_request             (i_request),
        .i_greedy              (i_greedy),
        .i_agent_action_valid  (i_agent_action_valid),
        .i_agent_action_data   (i_agent_action_data),
        .o_agent_action_ready  (o_agent_action_ready),
        .o_agent_action_gready (o_agent_action_gready),
        .o_agent_reward_valid  (o_agent_reward_valid),
        .o_agent_reward_data   (o_agent_reward_data),
        .i_agent_reward_ready  (i_agent_reward_ready),
        .o_action_valid        (o_action_valid),
        .i_action_ready        (i_action_ready),
        .o_action_data         (o_action_data),
        .i_reward_valid        (i_reward_valid),
        .o_reward_ready        (o_reward_ready),
        .i_reward_data         (i_reward_data),
        .o_grant               (o_grant)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Full transaction for owner g, starting in ACTUATING and ending back in IDLE.
    task automatic txn(input int g, input logic [7:0] act, input logic [7:0] rew);
        logic [N-1:0] oh;
        oh = 4'b0001 << g;
        check("txn_grant", 32'(o_grant), 32'(oh));
        check("txn_gready", 32'(o_agent_action_gready), 32'(i_greedy[g]));
        i_agent_action_valid = 1'b1;
        i_agent_action_data  = act;
        i_action_ready       = oh;
        #1;
        check("txn_action_valid", 32'(o_action_valid), 32'(oh));
        check("txn_action_data", 32'(o_action_data), 32'(act));
        check("txn_agent_action_ready", 32'(o_agent_action_ready), 32'd1);
        tick();
        i_agent_action_valid = 1'b0;
        i_action_ready       = '0;
        i_reward_valid       = oh;
        i_reward_data[8*g +: 8] = rew;
        i_agent_reward_ready = 1'b1;
        #1;
        check("txn_obs_action_valid", 32'(o_action_valid), 32'd0);
        check("txn_agent_reward_valid", 32'(o_agent_reward_valid), 32'd1);
        check("txn_agent_reward_data", 32'(o_agent_reward_data), 32'(rew));
        check("txn_reward_ready", 32'(o_reward_ready), 32'(oh));
        tick();
        i_reward_valid       = '0;
        i_agent_reward_ready = 1'b0;
        #1;
        check("txn_grant_cleared", 32'(o_grant), 32'd0);
        check("txn_idle_gready", 32'(o_agent_action_gready), 32'd1);
    endtask

    initial begin
        i_rst_n              = 1'b0;
        i_request            = '0;
        i_greedy             = '0;
        i_agent_action_valid = 1'b0;
        i_agent_action_data  = '0;
        i_agent_reward_ready = 1'b0;
        i_action_ready       = '0;
        i_reward_valid       = '0;
        i_reward_data        = '0;

        // Reset state
        #12;
        check("rst_grant", 32'(o_grant), 32'd0);
        check("rst_action_valid", 32'(o_action_valid), 32'd0);
        check("rst_reward_ready", 32'(o_reward_ready), 32'd0);
        check("rst_agent_reward_valid", 32'(o_agent_reward_valid), 32'd0);
        check("rst_agent_action_ready", 32'(o_agent_action_ready), 32'd0);
        check("rst_gready", 32'(o_agent_action_gready), 32'd1);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();

        // request 1010 -> requester 1 first, then requester 3
        i_request = 4'b1010;
        #1;
        check("no_comb_grant", 32'(o_grant), 32'd0);
        tick();
        check("rr_first_1", 32'(o_grant), 32'b0010);
        check("act_valid_before_agent", 32'(o_action_valid), 32'd0);
        txn(1, 8'hA5, 8'h22);
        tick();
        check("rr_then_3", 32'(o_grant), 32'b1000);
        txn(3, 8'h5A, 8'h33);

        // All requesting: 0,1,2,3,0
        i_request = 4'b1111;
        tick();
        txn(0, 8'h01, 8'h40);
        tick();
        txn(1, 8'h02, 8'h41);
        tick();
        txn(2, 8'h03, 8'h42);
        tick();
        txn(3, 8'h04, 8'h43);
        tick();
        txn(0, 8'h05, 8'h44);

        // Greedy owner 1 with reward 0x10
        i_request = 4'b0010;
        i_greedy  = 4'b0010;
        tick();
        check("greedy_gready", 32'(o_agent_action_gready), 32'd1);
        txn(1, 8'h77, 8'h10);
        i_greedy  = '0;

        // Owner 2 stalled by action_ready; request dropped mid-transaction
        i_request = 4'b0100;
        tick();
        check("stall_grant", 32'(o_grant), 32'b0100);
        i_request            = '0;
        i_agent_action_valid = 1'b1;
        i_agent_action_data  = 8'h37;
        i_action_ready       = 4'b1011;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("stall_data", 32'(o_action_data), 32'h37);
            check("stall_valid", 32'(o_action_valid), 32'b0100);
            check("stall_ready", 32'(o_agent_action_ready), 32'd0);
        end
        i_action_ready = 4'b0100;
        tick();
        i_agent_action_valid = 1'b0;
        i_action_ready       = '0;
        i_reward_valid       = 4'b1111;
        i_reward_data        = 32'hD4C3B2A1;
        i_agent_reward_ready = 1'b1;
        #1;
        check("others_reward_ready", 32'(o_reward_ready), 32'b0100);
        check("owner2_reward_data", 32'(o_agent_reward_data), 32'hC3);
        tick();
        i_reward_valid       = '0;
        i_agent_reward_ready = 1'b0;
        check("stall_done_grant", 32'(o_grant), 32'd0);

`ifdef ACTION_ARBITER_TIMEOUT_EN
        // Silent requester 0: penalty after 4 observing cycles
        i_request = 4'b0001;
        tick();
        check("to_grant", 32'(o_grant), 32'b0001);
        i_request            = '0;
        i_agent_action_valid = 1'b1;
        i_action_ready       = 4'b0001;
        tick();
        i_agent_action_valid = 1'b0;
        i_action_ready       = '0;
        tick();
        tick();
        tick();
        check("to_not_yet", 32'(o_agent_reward_valid), 32'd0);
        tick();
        check("to_valid", 32'(o_agent_reward_valid), 32'd1);
        check("to_data", 32'(o_agent_reward_data), 32'h80);
        check("to_reward_ready", 32'(o_reward_ready), 32'd0);
        i_agent_reward_ready = 1'b1;
        tick();
        i_agent_reward_ready = 1'b0;
        check("to_idle", 32'(o_grant), 32'd0);
`endif

        // Reset during OBSERVING abandons the transaction
        i_request = 4'b1000;
        tick();
        check("rst_mid_grant", 32'(o_grant), 32'b1000);
        i_request            = '0;
        i_agent_action_valid = 1'b1;
        i_action_ready       = 4'b1000;
        tick();
        i_agent_action_valid = 1'b0;
        i_action_ready       = '0;
        i_reward_valid       = 4'b1000;
        #1;
        check("rst_mid_reward_valid", 32'(o_agent_reward_valid), 32'd1);
        #1;
        i_rst_n = 1'b0;
        #1;
        check("rst_mid_grant0", 32'(o_grant), 32'd0);
        check("rst_mid_no_reward", 32'(o_agent_reward_valid), 32'd0);
        check("rst_mid_reward_ready", 32'(o_reward_ready), 32'd0);
        i_reward_valid = '0;
        @(negedge i_clk);
        i_rst_n   = 1'b1;
        i_request = 4'b1001;
        tick();
        check("post_rst_first_0", 32'(o_grant), 32'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
